// File: rtl/sd_wr_sched.sv
// sd_wr_sched: ping-pong sample buffer that hands each full 256-word bank to the SD block writer
module sd_wr_sched #(
  parameter logic [31:0] START_SEC = 32'd20000,
  parameter logic [31:0] SEC_NUM = 32'd1024
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        rec_en,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  output logic [15:0] wr_data,
  output logic        blk_done,
  output logic        wrap,
  output logic        overflow
);
  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] ram [0:511];
  logic [1:0] full;
  logic fill_bank, rd_bank;
  logic [7:0] fill_idx, rd_idx;
  logic [31:0] sec_idx, sec_nxt;
  logic take, last;
  assign take = smp_valid & rec_en & ~full[fill_bank];
  assign last = sec_idx == SEC_NUM - 32'd1;
  assign sec_nxt = last ? 32'd0 : sec_idx + 32'd1;
  always_ff @(posedge clk_ref)
    if (take) ram[{fill_bank, fill_idx}] <= smp_data;
  always_ff @(posedge clk_ref)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    wr_start_en = 1'b0;
    blk_done = 1'b0;
    wrap = 1'b0;
    case (state)
      IDLE: state_nxt = (sd_init_done & full[rd_bank] & ~wr_busy) ? START : IDLE;
      START: begin
        wr_start_en = 1'b1;
        state_nxt = wr_busy ? XFER : START;
      end
      XFER: state_nxt = wr_busy ? XFER : DONE;
      DONE: begin
        blk_done = 1'b1;
        wrap = last;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_ref)
    if (!rst_n) begin
      full <= 2'b00;
      fill_bank <= 1'b0;
      fill_idx <= 8'd0;
      rd_bank <= 1'b0;
      rd_idx <= 8'd0;
      sec_idx <= 32'd0;
      wr_sec_addr <= START_SEC;
      wr_data <= 16'd0;
      overflow <= 1'b0;
    end else begin
      if (smp_valid & rec_en & full[fill_bank]) overflow <= 1'b1;
      if (take) begin
        fill_idx <= fill_idx + 8'd1;
        if (fill_idx == 8'hff) begin
          full[fill_bank] <= 1'b1;
          fill_bank <= ~fill_bank;
        end
      end
      if (state == IDLE) rd_idx <= 8'd0;
      // read index saturates so surplus requests keep returning the last word
      if (state == XFER && wr_req) begin
        wr_data <= ram[{rd_bank, rd_idx}];
        if (rd_idx != 8'hff) rd_idx <= rd_idx + 8'd1;
      end
      if (state == DONE) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
        sec_idx <= sec_nxt;
        wr_sec_addr <= START_SEC + sec_nxt;
      end
    end
endmodule

// File: tb/tb_sd_wr_sched.sv
// tb_sd_wr_sched: randomized bench for sd_wr_sched with a behavioural writer and sample-stream model
module tb_sd_wr_sched;
  localparam logic [31:0] START_SEC = 32'd20000;
  localparam int SEC_N = 2;
  logic clk_ref = 1'b0, rst_n = 1'b0, sd_init_done = 1'b0, rec_en = 1'b0, smp_valid = 1'b0;
  logic [15:0] smp_data = 16'd0;
  logic wr_busy, wr_req, wr_start_en, blk_done, wrap, overflow;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic writer_on = 1'b0, w_busy = 1'b0, w_req = 1'b0, man_busy = 1'b0, man_req = 1'b0;
  assign wr_busy = writer_on ? w_busy : man_busy;
  assign wr_req = writer_on ? w_req : man_req;
  int vectors = 0, miscompares = 0;
  int blk_cnt = 0, wrap_orphan = 0;
  int wrap_log[$];
  logic [15:0] rx[$];
  logic [31:0] addr_log[$];
  logic [15:0] exp_q[$];
  int acc, dropped, blk0, rx0, addr0, wrap0, orphan0, chk;

  sd_wr_sched #(.START_SEC(START_SEC), .SEC_NUM(32'(SEC_N))) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .sd_init_done(sd_init_done), .rec_en(rec_en),
    .smp_valid(smp_valid), .smp_data(smp_data), .wr_busy(wr_busy), .wr_req(wr_req),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_data(wr_data),
    .blk_done(blk_done), .wrap(wrap), .overflow(overflow)
  );

  always #5 clk_ref = ~clk_ref;

  task automatic tick;
    @(posedge clk_ref);
    #1;
  endtask

  always @(negedge clk_ref) begin
    if (wrap) wrap_log.push_back(blk_cnt + 1);
    if (wrap && !blk_done) wrap_orphan++;
    if (blk_done) blk_cnt++;
  end

  // SD writer: answers a start with busy, pulls 256 words with random pacing, then releases
  initial forever begin
    tick;
    if (writer_on && wr_start_en && !w_busy) begin
      addr_log.push_back(wr_sec_addr);
      repeat ($urandom_range(0, 2)) tick;
      w_busy = 1'b1;
      tick;
      for (int i = 0; i < 256; i++) begin
        repeat ($urandom_range(0, 2)) tick;
        w_req = 1'b1;
        tick;
        w_req = 1'b0;
        rx.push_back(wr_data);
      end
      repeat ($urandom_range(0, 2)) tick;
      w_busy = 1'b0;
    end
  end

  task automatic model_reset;
    blk0 = blk_cnt; rx0 = rx.size(); addr0 = addr_log.size();
    wrap0 = wrap_log.size(); orphan0 = wrap_orphan;
    exp_q.delete(); acc = 0; dropped = 0; chk = 0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; smp_valid = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Two banks of 256: a sample is kept only while fewer than 512 are buffered and unreleased
  task automatic feed(input int n, input bit en, input bit seq, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 1)) tick;
      smp_valid = 1'b1; rec_en = en;
      smp_data = seq ? 16'(i) : 16'($urandom);
      if (en) begin
        if (acc - 256 * (blk_cnt - blk0) < 512) begin exp_q.push_back(smp_data); acc++; end
        else dropped++;
      end
      tick;
      smp_valid = 1'b0;
    end
    rec_en = 1'b1;
  endtask

  task automatic wait_blocks(input int n, input string name);
    int t;
    t = 0;
    while (blk_cnt - blk0 < n && t < 20000) begin tick; t++; end
    repeat (4) tick;
    vectors++;
    if (blk_cnt - blk0 != n) begin
      miscompares++;
      $display("FAIL %s block count: got %0d want %0d", name, blk_cnt - blk0, n);
    end
  endtask

  task automatic check_data(input string name);
    int n, bad, at;
    logic [15:0] g, e;
    n = blk_cnt - blk0;
    for (int b = chk; b < n; b++) begin
      bad = 0; at = -1; g = 16'd0; e = 16'd0;
      for (int i = 0; i < 256; i++) begin
        if (rx0 + b * 256 + i >= rx.size() || b * 256 + i >= exp_q.size() ||
            rx[rx0 + b * 256 + i] !== exp_q[b * 256 + i]) begin
          if (at < 0) begin
            at = i;
            if (rx0 + b * 256 + i < rx.size()) g = rx[rx0 + b * 256 + i];
            if (b * 256 + i < exp_q.size()) e = exp_q[b * 256 + i];
          end
          bad++;
        end
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL %s data blk %0d: %0d bad words, first at %0d got %h want %h", name, b, bad, at, g, e);
      end
      vectors++;
      if (addr0 + b >= addr_log.size() || addr_log[addr0 + b] !== START_SEC + 32'(b % SEC_N)) begin
        miscompares++;
        $display("FAIL %s sector blk %0d: got %0d want %0d", name, b,
                 (addr0 + b < addr_log.size()) ? addr_log[addr0 + b] : 32'd0, START_SEC + 32'(b % SEC_N));
      end
    end
    chk = n;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({wr_start_en, blk_done, wrap, overflow, wr_data, wr_sec_addr} !== {4'b0, 16'h0, START_SEC}) begin
      miscompares++;
      $display("FAIL reset outputs: got start=%b done=%b wrap=%b ovf=%b data=%h addr=%0d want 0,0,0,0,0000,%0d",
               wr_start_en, blk_done, wrap, overflow, wr_data, wr_sec_addr, START_SEC);
    end
  endtask

  task automatic test_single_block;
    sd_init_done = 1'b1; writer_on = 1'b1;
    feed(256, 1'b1, 1'b1, 1'b1);
    wait_blocks(1, "single");
    check_data("single");
    vectors++;
    if (wr_sec_addr !== START_SEC + 32'd1) begin
      miscompares++;
      $display("FAIL single next addr: got %0d want %0d", wr_sec_addr, START_SEC + 32'd1);
    end
    vectors++;
    if (wrap_log.size() != wrap0) begin
      miscompares++;
      $display("FAIL single wrap: got %0d pulses want 0", wrap_log.size() - wrap0);
    end
  endtask

  task automatic test_wrap;
    feed(256, 1'b1, 1'b0, 1'b1);
    wait_blocks(2, "wrap b2");
    feed(256, 1'b1, 1'b0, 1'b1);
    wait_blocks(3, "wrap b3");
    check_data("wrap");
    vectors++;
    if (wrap_log.size() - wrap0 != 1 || wrap_log[wrap0] != blk0 + 2) begin
      miscompares++;
      $display("FAIL wrap pulses: got %0d pulses (first at blk %0d) want 1 at blk %0d",
               wrap_log.size() - wrap0, (wrap_log.size() > wrap0) ? wrap_log[wrap0] - blk0 : -1, 2);
    end
    vectors++;
    if (wrap_orphan != orphan0) begin
      miscompares++;
      $display("FAIL wrap without blk_done: got %0d want 0", wrap_orphan - orphan0);
    end
    vectors++;
    if (wr_sec_addr !== START_SEC + 32'd1) begin
      miscompares++;
      $display("FAIL wrap next addr: got %0d want %0d", wr_sec_addr, START_SEC + 32'd1);
    end
  endtask

  task automatic test_overflow;
    int seen;
    do_reset();
    writer_on = 1'b0; man_busy = 1'b1;
    feed(520, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (overflow !== (dropped != 0)) begin
      miscompares++;
      $display("FAIL overflow set: got %b want %b", overflow, dropped != 0);
    end
    seen = 0;
    repeat (1480) begin tick; if (wr_start_en !== 1'b0) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL overflow start while busy: got %0d cycles want 0", seen);
    end
    man_busy = 1'b0; writer_on = 1'b1;
    wait_blocks(2, "overflow");
    check_data("overflow");
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_init_gate;
    int seen;
    do_reset();
    sd_init_done = 1'b0; writer_on = 1'b0; man_busy = 1'b0;
    feed(256, 1'b1, 1'b0, 1'b1);
    seen = 0;
    repeat (40) begin tick; if (wr_start_en !== 1'b0) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL init gate start while uninitialised: got %0d cycles want 0", seen);
    end
    sd_init_done = 1'b1;
    vectors++;
    if (wr_start_en !== 1'b0) begin
      miscompares++;
      $display("FAIL init gate early start: got %b want 0", wr_start_en);
    end
    tick;
    vectors++;
    if (wr_start_en !== 1'b1) begin
      miscompares++;
      $display("FAIL init gate start: got %b want 1", wr_start_en);
    end
    writer_on = 1'b1;
    wait_blocks(1, "init gate");
    check_data("init gate");
  endtask

  task automatic test_reset_mid;
    int t, seen;
    do_reset();
    writer_on = 1'b0; man_busy = 1'b0;
    feed(256, 1'b1, 1'b0, 1'b1);
    t = 0;
    while (wr_start_en !== 1'b1 && t < 10) begin tick; t++; end
    vectors++;
    if (wr_start_en !== 1'b1) begin
      miscompares++;
      $display("FAIL reset mid start: got %b want 1", wr_start_en);
    end
    man_busy = 1'b1;
    tick;
    repeat (5) begin man_req = 1'b1; tick; man_req = 1'b0; tick; end
    rst_n = 1'b0;
    tick;
    vectors++;
    if ({wr_start_en, blk_done, wrap, overflow, wr_data, wr_sec_addr} !== {4'b0, 16'h0, START_SEC}) begin
      miscompares++;
      $display("FAIL reset mid outputs: got start=%b done=%b wrap=%b ovf=%b data=%h addr=%0d want 0,0,0,0,0000,%0d",
               wr_start_en, blk_done, wrap, overflow, wr_data, wr_sec_addr, START_SEC);
    end
    rst_n = 1'b1;
    model_reset();
    feed(256, 1'b1, 1'b0, 1'b1);
    seen = 0;
    repeat (20) begin tick; if (wr_start_en !== 1'b0) seen++; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset mid start while busy: got %0d cycles want 0", seen);
    end
    man_busy = 1'b0; writer_on = 1'b1;
    wait_blocks(1, "reset mid");
    check_data("reset mid");
  endtask

  task automatic test_rec_en_gap;
    do_reset();
    feed(100, 1'b1, 1'b0, 1'b1);
    feed(50, 1'b0, 1'b0, 1'b0);
    feed(156, 1'b1, 1'b0, 1'b1);
    wait_blocks(1, "rec_en gap");
    check_data("rec_en gap");
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rec_en gap overflow: got %b want 0", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_wrap();
    test_overflow();
    test_init_gate();
    test_reset_mid();
    test_rec_en_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
